// File: rtl/ask4_slicer.sv
// 4-ASK symbol decision stage after the RX matched filter.
// Decimates to one sample per symbol, slices it, and tracks the reference level.
module ask4_slicer #(
    parameter int          SPS      = 4,
    parameter int          AVG_LOG2 = 10,
    parameter logic [17:0] REF_INIT = 18'd32768,
    localparam int         PW       = (SPS > 1) ? $clog2(SPS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sam_clk_en,
    input  logic [17:0]   in,
    input  logic [PW-1:0] phase_sel,
    output logic          sym_valid,
    output logic [1:0]    sym_out,
    output logic [17:0]   sym_err,
    output logic [17:0]   ref_level,
    output logic          ref_valid
);

    localparam int AW = 18 + AVG_LOG2;

    logic [PW-1:0]       cnt_q;
    logic                strobe;

    logic                s1_v_q;
    logic signed [17:0]  x_q;
    logic [17:0]         a_q;
    logic [17:0]         abs_d;

    logic                sv_q;
    logic [1:0]          so_q;
    logic [17:0]         se_q;
    logic [1:0]          so_d;
    logic [17:0]         se_d;

    logic [AW-1:0]       acc_q;
    logic [AW-1:0]       acc_d;
    logic [AVG_LOG2-1:0] scnt_q;
    logic [17:0]         ref_q;
    logic                refv_q;

    logic signed [19:0]  xs;
    logic signed [19:0]  rs;
    logic signed [19:0]  hs;
    logic signed [19:0]  r3;
    logic signed [19:0]  ideal;
    logic signed [19:0]  err20;

    assign strobe = sam_clk_en && (cnt_q == phase_sel);

    // Magnitude of the input, with the most negative code clamped.
    always_comb begin
        abs_d = in;
        if (in[17]) begin
            if (in == 18'h20000) begin
                abs_d = 18'h1FFFF;
            end else begin
                abs_d = 18'(-$signed(in));
            end
        end
    end

    // Sample phase counter, advancing only on enabled samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (sam_clk_en) begin
            if (cnt_q == PW'(SPS - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Stage 1: capture the decimated sample and its magnitude.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q <= 1'b0;
            x_q    <= '0;
            a_q    <= '0;
        end else begin
            s1_v_q <= strobe;
            if (strobe) begin
                x_q <= $signed(in);
                a_q <= abs_d;
            end
        end
    end

    // Decision thresholds and ideal levels in 20 bits so nothing wraps.
    always_comb begin
        xs    = 20'(x_q);
        rs    = $signed({2'b00, ref_q});
        hs    = $signed({3'b000, ref_q[17:1]});
        r3    = rs + hs;
        so_d  = 2'b00;
        ideal = -r3;
        if (xs >= rs) begin
            so_d  = 2'b11;
            ideal = r3;
        end else if (xs >= 20'sd0) begin
            so_d  = 2'b10;
            ideal = hs;
        end else if (xs >= -rs) begin
            so_d  = 2'b01;
            ideal = -hs;
        end
        err20 = xs - ideal;
        if (err20 > 20'sd131071) begin
            se_d = 18'h1FFFF;
        end else if (err20 < -20'sd131072) begin
            se_d = 18'h20000;
        end else begin
            se_d = err20[17:0];
        end
    end

    // Stage 2: register the decision and its error, held between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sv_q <= 1'b0;
            so_q <= '0;
            se_q <= '0;
        end else begin
            sv_q <= s1_v_q;
            if (s1_v_q) begin
                so_q <= so_d;
                se_q <= se_d;
            end
        end
    end

    assign acc_d = acc_q + AW'(a_q);

    // Reference estimate: mean magnitude over each window of symbols.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            scnt_q <= '0;
            ref_q  <= REF_INIT;
            refv_q <= 1'b0;
        end else if (s1_v_q) begin
            if (scnt_q == '1) begin
                ref_q  <= acc_d[AW-1:AVG_LOG2];
                acc_q  <= '0;
                scnt_q <= '0;
                refv_q <= 1'b1;
            end else begin
                acc_q  <= acc_d;
                scnt_q <= scnt_q + 1'b1;
            end
        end
    end

    assign sym_valid = sv_q;
    assign sym_out   = so_q;
    assign sym_err   = se_q;
    assign ref_level = ref_q;
    assign ref_valid = refv_q;

endmodule
